// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped 8N1 UART for the CPU peripheral bus.
//
// Registers (only full 32-bit addresses decode; everything else reads 0):
//   0x40000018 TXD  write starts a frame (ignored while busy), reads last byte
//   0x4000001C RXD  last received byte (read clears RXFULL)
//   0x40000020 CON  {FERR, TXBUSY, RXFULL, TXDONE, RXIE, TXIE}
//                   Bits [1:0] are writable. A read clears TXDONE and FERR.
//
// Ports:
//   reset   asynchronous, active-low
//   clk     system clock, rising edge
//   rd/wr   bus strobes; addr/wdata byte address and write data
//   rdata   combinational read data, 0 when rd=0
//   UART_RX serial input (asynchronous); UART_TX serial output, idle high
//   irq     level interrupt (TXIE & TXDONE) | (RXIE & RXFULL)
module uart_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        irq
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  // The stop bit runs one extra cycle so the idle/done transition lines up
  // with the registered line output, which lags the FSM by one cycle.
  localparam logic [CW-1:0] STOP_LAST = CW'(DIV);

  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic wr_txd, wr_con, rd_con, rd_rxd;
  assign wr_txd = wr && (addr == A_TXD);
  assign wr_con = wr && (addr == A_CON);
  assign rd_con = rd && (addr == A_CON);
  assign rd_rxd = rd && (addr == A_RXD);

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  logic [7:0] txd, rxd;
  logic       txie, rxie, tx_done, rx_full, ferr;

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]    tx_bit, tx_bit_nx;
  logic          tx_load, tx_fin, tx_line_nx, tx_busy;

  assign tx_busy = (tx_state != TX_IDLE);

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt + 1'b1;
    tx_bit_nx   = tx_bit;
    tx_load     = 1'b0;
    tx_fin      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nx = '0;
        if (wr_txd) begin
          tx_load     = 1'b1;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == DIV_LAST) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = 3'd0;
          tx_state_nx = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == DIV_LAST) begin
          tx_cnt_nx = '0;
          if (tx_bit == 3'd7) tx_state_nx = TX_STOP;
          else                tx_bit_nx   = tx_bit + 3'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == STOP_LAST) begin
          tx_cnt_nx   = '0;
          tx_fin      = 1'b1;
          tx_state_nx = TX_IDLE;
        end
      end
      default: begin
        tx_cnt_nx   = '0;
        tx_state_nx = TX_IDLE;
      end
    endcase
  end

  // Line level for the current state; registered so UART_TX is glitch-free.
  always_comb begin
    tx_line_nx = 1'b1;
    if (tx_state == TX_START)     tx_line_nx = 1'b0;
    else if (tx_state == TX_DATA) tx_line_nx = txd[tx_bit];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      UART_TX  <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      UART_TX  <= tx_line_nx;
    end
  end

  // ---------------- receiver ----------------
  logic rx_s1, rx_s2, rx_prev;

  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]    rx_bit, rx_bit_nx;
  logic [7:0]    rx_shift, rx_shift_nx;
  logic          rx_done, rx_ferr;

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt + 1'b1;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_done     = 1'b0;
    rx_ferr     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nx = '0;
        if (rx_prev && !rx_s2) rx_state_nx = RX_START;
      end
      RX_START: begin
        // Re-check at mid start bit; a high line here was only a glitch.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nx = '0;
          rx_bit_nx = 3'd0;
          rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == DIV_LAST) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
          else                rx_bit_nx   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == DIV_LAST) begin
          rx_cnt_nx   = '0;
          rx_done     = rx_s2;
          rx_ferr     = !rx_s2;
          rx_state_nx = RX_IDLE;
        end
      end
      default: begin
        rx_cnt_nx   = '0;
        rx_state_nx = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= UART_RX;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  // ---------------- registers and flags ----------------
  // Hardware set events take priority over read-side clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txd     <= '0;
      rxd     <= '0;
      txie    <= 1'b0;
      rxie    <= 1'b0;
      tx_done <= 1'b0;
      rx_full <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (tx_load) txd <= wdata[7:0];
      if (wr_con) begin
        txie <= wdata[0];
        rxie <= wdata[1];
      end
      if (tx_fin)      tx_done <= 1'b1;
      else if (rd_con) tx_done <= 1'b0;
      if (rx_ferr)     ferr <= 1'b1;
      else if (rd_con) ferr <= 1'b0;
      if (rx_done) begin
        rxd     <= rx_shift;
        rx_full <= 1'b1;
      end else if (rd_rxd) begin
        rx_full <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (addr)
        A_TXD:   rdata = {24'b0, txd};
        A_RXD:   rdata = {24'b0, rxd};
        A_CON:   rdata = {26'b0, ferr, tx_busy, rx_full, tx_done, rxie, txie};
        default: rdata = '0;
      endcase
    end
  end

  assign irq = (txie & tx_done) | (rxie & rx_full);

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl with CLK_FREQ=16, BAUD=1 (DIV=16).
module tb_uart_ctrl;
  localparam int DIV = 16;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
  localparam logic [31:0] A_BAD = 32'h4000_0024;

  logic        clk = 1'b0;
  logic        reset, rd, wr, uart_rx, uart_tx, irq;
  logic [31:0] addr, wdata, rdata;

  always #5 clk = ~clk;

  uart_ctrl #(.CLK_FREQ(16), .BAUD(1)) dut (
    .reset(reset), .clk(clk), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .UART_RX(uart_rx), .UART_TX(uart_tx), .irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The transmitter is described by when the accepted write happened: the
  // frame occupies cycles k+1 .. k+10*DIV after write edge k, and TXDONE
  // appears at edge k+1+10*DIV. Received bytes are posted by the RX driver.
  int         cyc     = 0;
  int         m_tx_k  = -1;
  logic [7:0] m_txd   = '0, m_rxd = '0;
  logic       m_txie  = 0, m_rxie = 0, m_txdone = 0, m_rxfull = 0, m_ferr = 0;
  bit         rx_active = 0, rx_req = 0, rx_req_ok = 0;
  logic [7:0] rx_req_byte = '0;

  function automatic logic m_busy(input int t);
    return (m_tx_k >= 0) && (t < m_tx_k + 1 + 10 * DIV);
  endfunction

  function automatic logic m_line(input int t);
    int idx;
    if (m_tx_k < 0 || t < m_tx_k + 1 || t > m_tx_k + 10 * DIV) return 1'b1;
    idx = (t - m_tx_k - 1) / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_txd[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input int t);
    case (a)
      A_TXD:   return {24'b0, m_txd};
      A_RXD:   return {24'b0, m_rxd};
      A_CON:   return {26'b0, m_ferr, m_busy(t), m_rxfull, m_txdone, m_rxie, m_txie};
      default: return 32'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      m_tx_k = -1; m_txd = '0; m_rxd = '0;
      m_txie = 0; m_rxie = 0; m_txdone = 0; m_rxfull = 0; m_ferr = 0;
      rx_req = 0;
      check("reset_tx_line", 32'(uart_tx), 32'd1);
      check("reset_irq", 32'(irq), 32'd0);
    end else begin
      logic busy;
      cyc++;
      check("tx_line", 32'(uart_tx), 32'(m_line(cyc)));
      if (!rx_active) check("irq", 32'(irq), 32'((m_txie & m_txdone) | (m_rxie & m_rxfull)));
      if (rd && !rx_active) check("rdata", rdata, m_read(addr, cyc));
      // advance model across the next rising edge
      busy = m_busy(cyc);
      if (rd && addr == A_CON) begin m_txdone = 0; m_ferr = 0; end
      if (rd && addr == A_RXD) m_rxfull = 0;
      if (m_tx_k >= 0 && cyc + 1 == m_tx_k + 1 + 10 * DIV) m_txdone = 1;
      if (wr && addr == A_CON) begin m_txie = wdata[0]; m_rxie = wdata[1]; end
      if (wr && addr == A_TXD && !busy) begin m_txd = wdata[7:0]; m_tx_k = cyc + 1; end
      if (rx_req) begin
        if (rx_req_ok) begin m_rxd = rx_req_byte; m_rxfull = 1; end
        else m_ferr = 1;
        rx_req = 0;
      end
    end
  end

  // ---------------- bus and line drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    #2 d = rdata;
    @(posedge clk); #1;
    rd = 1'b0; addr = '0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      idle(DIV);
    end
    uart_rx = 1'b1;
    rx_req_byte = b; rx_req_ok = stop; rx_req = 1;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] d;
  logic [9:0]  a5_bits;

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; uart_rx = 1'b1;
    a5_bits = 10'b11_1010_0101 ^ 10'b00_0000_0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // reset state
    check("idle_rdata_rd0", rdata, 32'h0);
    bus_read(A_CON, d); check("rst_con", d, 32'h0);
    bus_read(A_TXD, d); check("rst_txd", d, 32'h0);
    bus_read(A_RXD, d); check("rst_rxd", d, 32'h0);

    // TX 0xA5: line must show 0, 1,0,1,0,0,1,0,1, 1 (start, LSB first, stop)
    bus_write(A_CON, 32'h1);
    bus_write(A_TXD, 32'hA5);
    idle(8);
    for (int i = 0; i < 10; i++) begin
      logic [0:9] exp_seq;
      exp_seq = 10'b0101001011;
      check($sformatf("a5_bit%0d", i), 32'(uart_tx), 32'(exp_seq[i]));
      if (i == 4) begin
        bus_read(A_CON, d); check("tx_busy_con", d, 32'h11);
        idle(15);
      end else begin
        idle(16);
      end
    end
    check("tx_irq", 32'(irq), 32'd1);
    addr = A_CON; #1 check("rdata_rd0", rdata, 32'h0); addr = '0;
    bus_read(A_CON, d); check("con_done", d, 32'h05);
    bus_read(A_CON, d); check("con_cleared", d, 32'h01);

    // write during a frame is ignored
    bus_write(A_TXD, 32'hA5);
    idle(40);
    bus_write(A_TXD, 32'hFF);
    bus_read(A_TXD, d); check("txd_keep", d, 32'hA5);
    idle(130);
    bus_read(A_CON, d); check("con_done2", d, 32'h05);
    bus_read(A_CON, d); check("con_cleared2", d, 32'h01);

    // RX 0x3C with RXIE
    bus_write(A_CON, 32'h2);
    rx_active = 1;
    send_frame(8'h3C, 1'b1);
    idle(2);
    rx_active = 0;
    check("rx_irq", 32'(irq), 32'd1);
    bus_read(A_CON, d); check("rx_con_full", d, 32'h0A);
    bus_read(A_RXD, d); check("rx_byte", d, 32'h3C);
    check("rx_irq_clr", 32'(irq), 32'd0);
    bus_read(A_CON, d); check("rx_con_clr", d, 32'h02);

    // framing error
    rx_active = 1;
    send_frame(8'h55, 1'b0);
    idle(2);
    rx_active = 0;
    bus_read(A_CON, d); check("ferr_set", d, 32'h22);
    bus_read(A_CON, d); check("ferr_clr", d, 32'h02);
    bus_read(A_RXD, d); check("ferr_rxd", d, 32'h3C);

    // RXD write ignored, glitch rejected, then overrun
    bus_write(A_RXD, 32'h99);
    rx_active = 1;
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(30);
    rx_active = 0;
    bus_read(A_CON, d); check("glitch_con", d, 32'h02);
    rx_active = 1;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2);
    rx_active = 0;
    bus_read(A_CON, d); check("ovr_con", d, 32'h0A);
    bus_read(A_RXD, d); check("ovr_rxd", d, 32'h22);

    // reset in the middle of a frame (0x5A bit 2 is 0 at this point)
    bus_write(A_CON, 32'h3);
    bus_write(A_TXD, 32'h5A);
    idle(50);
    check("pre_rst_line", 32'(uart_tx), 32'd0);
    #2 reset = 1'b0;
    #1 check("rst_mid_tx", 32'(uart_tx), 32'd1);
    check("rst_mid_irq", 32'(irq), 32'd0);
    idle(2);
    reset = 1'b1;
    bus_read(A_CON, d); check("post_rst_con", d, 32'h0);
    bus_read(A_BAD, d); check("bad_addr", d, 32'h0);
    bus_read(A_TXD, d); check("post_rst_txd", d, 32'h0);
    idle(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Memory-mapped UART controller attached to the single-cycle CPU's data bus in the peripheral address space (address bit 30 set). It serialises bytes written by software onto `UART_TX`, deserialises bytes from `UART_RX` into a receive register, and raises a level interrupt toward the CPU's IRQ input. Reads are combinational so a `lw` completes in the same cycle; all state updates occur on `clk` rising edges.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate. `DIV = CLK_FREQ/BAUD` (integer division), required `DIV >= 4`.
- `reset`  in  1  asynchronous, active-low
- `clk`  in  1  system clock, rising edge
- `rd`  in  1  bus read strobe (CPU MemRd)
- `wr`  in  1  bus write strobe (CPU MemWr)
- `addr`  in  32  byte address (CPU ALU result)
- `wdata`  in  32  write data (CPU register Rt)
- `rdata`  out  32  read data, combinational
- `UART_RX`  in  1  serial input, asynchronous to `clk`
- `UART_TX`  out  1  serial output, idle high
- `irq`  out  1  level interrupt request

## Operation
- Register map. Only the full 32-bit address is decoded; any other address reads 0, and writes to it are ignored.
  - `0x40000018` TXD: write bits [7:0] to start a transmission; reads return {24'b0, last written byte}.
  - `0x4000001C` RXD: reads return {24'b0, rx byte}; writes are ignored.
  - `0x40000020` CON: bit0 TXIE (rw), bit1 RXIE (rw), bit2 TXDONE (ro), bit3 RXFULL (ro), bit4 TXBUSY (ro), bit5 FERR (ro); bits [31:6] read 0. A write updates only bits [1:0].
- Read side effects are applied at the clock edge where `rd`=1 and the address matches:
  - A CON read clears TXDONE and FERR.
  - An RXD read clears RXFULL.
- Frame format: 8N1. One low start bit, 8 data bits LSB first, one high stop bit. Each bit lasts `DIV` cycles.
- TX FSM, states IDLE → START → DATA(bit 0..7) → STOP → IDLE.
  - A TXD write in IDLE latches the byte and enters START.
  - A TXD write in any other state is ignored: neither the byte register nor the frame changes.
  - At the end of STOP the FSM sets TXDONE, clears TXBUSY, and returns to IDLE.
  - TXBUSY = (state != IDLE).
- RX path: `UART_RX` passes through a 2-flop synchroniser before any use.
- RX FSM, states IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronised 1→0 transition enters START.
  - START: waits `DIV/2` cycles, then re-samples the line. If it is high, the FSM returns to IDLE (glitch). Otherwise it enters DATA.
  - DATA: samples every `DIV` cycles, 8 samples, shifted in LSB first.
  - STOP: samples once after `DIV` cycles. If the sample is high, RXD ← byte and RXFULL ← 1. If it is low, FERR ← 1 and RXD is unchanged. In both cases the FSM returns to IDLE.
- Overrun: a new byte received while RXFULL=1 overwrites RXD, and RXFULL stays 1. There is no overrun flag.
- `irq` = (TXIE & TXDONE) | (RXIE & RXFULL), driven from registers with no combinational path from the bus.
- Simultaneous events:
  - RX completion and RXD read in the same cycle: the set wins, so RXFULL=1 and RXD holds the new byte.
  - TX completion and CON read in the same cycle: the set wins, so TXDONE=1.
  - Framing error and CON read in the same cycle: FERR=1.
  - CON write and CON read in the same cycle: the write updates bits [1:0] and the read clears bits 2 and 5.

## Timing
- Reset values: `UART_TX`=1, `irq`=0, both FSMs IDLE, TXIE=TXIE=RXIE=0, TXDONE=RXFULL=FERR=0, TXD=RXD=0, synchroniser flops=1, all counters 0.
- `rdata` is a function of `addr`, `rd`, and register state. It is 0 when `rd`=0.
- TX latency: for a TXD write sampled at edge k, `UART_TX` falls after edge k+1. Each bit is held for exactly `DIV` cycles. TXDONE and `irq` rise after edge k+1+10·DIV.
- RX latency: for a start edge seen at the synchroniser output at edge s, RXFULL rises after edge s+DIV/2+9·DIV+1 (±1 cycle, bounded). The line-to-synchroniser delay is 2 cycles.
- Reset mid-frame: asserting `reset` (low) immediately forces `UART_TX` high and aborts both FSMs. A partially received byte is discarded.

## Test plan
- `CLK_FREQ`=16, `BAUD`=1 (`DIV`=16). Write TXD=0xA5 → `UART_TX` shows 0, 1,0,1,0,0,1,0,1, 1, each bit 16 cycles. TXBUSY=1 during the frame. TXDONE=1 after 160 cycles.
- Drive an RX frame for 0x3C with RXIE=1 → RXFULL=1, `irq`=1, RXD reads 0x3C. After an RXD read: RXFULL=0 and `irq`=0.
- During a TX frame, write TXD=0xFF → the frame still carries 0xA5 and the TXD readback stays 0xA5. A CON read after completion returns 0x05 with TXIE=1, and the following CON read returns 0x01.
- RX frame 0x55 with the stop bit driven low → FERR=1, RXFULL=0, RXD unchanged. A CON read clears FERR.
- A 4-cycle low glitch on `UART_RX` → no byte and no FERR. Then two back-to-back frames 0x11 and 0x22 with no RXD read → RXD=0x22 and RXFULL=1.
- Assert `reset` low mid-TX → `UART_TX`=1 immediately, all CON bits 0, `irq`=0. Reading address 0x40000024 returns 0.
